// File: rtl/shift_issue.sv
// Two-stage shift issue pipeline: S1 decodes and drives the external shifter, S2 holds the result.
// Optional `SHIFT_OVF_SAT_EN: shift amounts >= 32 saturate instead of wrapping modulo 32.
module shift_issue #(
  parameter int TAG_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       IN_OP,
  input  logic [31:0]      IN_A,
  input  logic [7:0]       IN_B,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic [31:0]      SH_X,
  output logic [4:0]       SH_S,
  output logic             SH_LEFT,
  output logic             SH_LOG,
  input  logic [31:0]      SH_Z,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      OUT_Z,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             OUT_ERR,
  output logic [15:0]      OP_CNT
);

  logic             s1_vld_q, s1_vld_d;
  logic [31:0]      s1_x_q;
  logic [4:0]       s1_s_q;
  logic             s1_left_q, s1_log_q, s1_err_q;
  logic [TAG_W-1:0] s1_tag_q;
`ifdef SHIFT_OVF_SAT_EN
  logic             s1_ovf_q;
`else
  logic             unused_b_hi;
  assign unused_b_hi = ^IN_B[7:5];
`endif

  logic             s2_vld_q, s2_vld_d;
  logic [31:0]      s2_z_q, s2_z_d;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_err_q;
  logic [15:0]      cnt_q;

  logic s2_free, s1_adv, accept;

  assign s2_free  = !s2_vld_q | OUT_READY;
  assign s1_adv   = s1_vld_q & s2_free;
  assign IN_READY = !s1_vld_q | s2_free;
  assign accept   = IN_VALID & IN_READY;

  always_comb begin
    s1_vld_d = s1_vld_q;
    if (accept)      s1_vld_d = 1'b1;
    else if (s1_adv) s1_vld_d = 1'b0;

    s2_vld_d = s2_vld_q;
    if (s1_adv)       s2_vld_d = 1'b1;
    else if (s2_free) s2_vld_d = 1'b0;
  end

  // Reserved ops always retire as zero, overriding any saturation.
  always_comb begin
    s2_z_d = SH_Z;
`ifdef SHIFT_OVF_SAT_EN
    if (s1_ovf_q) s2_z_d = (s1_left_q | s1_log_q) ? 32'h0 : {32{s1_x_q[31]}};
`endif
    if (s1_err_q) s2_z_d = 32'h0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_vld_q  <= 1'b0;
      s1_x_q    <= '0;
      s1_s_q    <= '0;
      s1_left_q <= 1'b0;
      s1_log_q  <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_tag_q  <= '0;
`ifdef SHIFT_OVF_SAT_EN
      s1_ovf_q  <= 1'b0;
`endif
    end else begin
      s1_vld_q <= s1_vld_d;
      if (accept) begin
        s1_x_q    <= IN_A;
        s1_s_q    <= IN_B[4:0];
        s1_left_q <= (IN_OP == 2'b00);
        s1_log_q  <= (IN_OP != 2'b10);
        s1_err_q  <= (IN_OP == 2'b11);
        s1_tag_q  <= IN_TAG;
`ifdef SHIFT_OVF_SAT_EN
        s1_ovf_q  <= (IN_B[7:5] != 3'b000);
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s2_vld_q <= 1'b0;
      s2_z_q   <= '0;
      s2_tag_q <= '0;
      s2_err_q <= 1'b0;
    end else begin
      s2_vld_q <= s2_vld_d;
      if (s1_adv) begin
        s2_z_q   <= s2_z_d;
        s2_tag_q <= s1_tag_q;
        s2_err_q <= s1_err_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                         cnt_q <= '0;
    else if (accept && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign SH_X      = s1_x_q;
  assign SH_S      = s1_s_q;
  assign SH_LEFT   = s1_left_q;
  assign SH_LOG    = s1_log_q;
  assign OUT_VALID = s2_vld_q;
  assign OUT_Z     = s2_z_q;
  assign OUT_TAG   = s2_tag_q;
  assign OUT_ERR   = s2_err_q;
  assign OP_CNT    = cnt_q;

endmodule

// File: tb/tb_shift_issue.sv
// Bench for shift_issue: directed cases plus random traffic against a queue-based reference model.
module tb_shift_issue;
  localparam int TW = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          IN_VALID, IN_READY, OUT_READY;
  logic [1:0]    IN_OP;
  logic [31:0]   IN_A;
  logic [7:0]    IN_B;
  logic [TW-1:0] IN_TAG;
  logic [31:0]   SH_X, SH_Z, OUT_Z;
  logic [4:0]    SH_S;
  logic          SH_LEFT, SH_LOG, OUT_VALID, OUT_ERR;
  logic [TW-1:0] OUT_TAG;
  logic [15:0]   OP_CNT;

  shift_issue #(.TAG_W(TW)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_OP(IN_OP), .IN_A(IN_A), .IN_B(IN_B), .IN_TAG(IN_TAG),
    .SH_X(SH_X), .SH_S(SH_S), .SH_LEFT(SH_LEFT), .SH_LOG(SH_LOG), .SH_Z(SH_Z),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_Z(OUT_Z),
    .OUT_TAG(OUT_TAG), .OUT_ERR(OUT_ERR), .OP_CNT(OP_CNT)
  );

  always #5 CLK = ~CLK;

  // External combinational shifter
  always_comb begin
    if (SH_LEFT)     SH_Z = SH_X << SH_S;
    else if (SH_LOG) SH_Z = SH_X >> SH_S;
    else             SH_Z = 32'($signed(SH_X) >>> SH_S);
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_z(input logic [1:0] op, input logic [31:0] a, input logic [7:0] b);
    int unsigned amt;
    logic [31:0] fill;
    amt = b % 32;
    if (op == 2'd3) return 32'h0;
`ifdef SHIFT_OVF_SAT_EN
    if (b >= 8'd32) return (op == 2'd2) ? {32{a[31]}} : 32'h0;
`endif
    fill = a[31] ? ~(32'hFFFFFFFF >> amt) : 32'h0;
    case (op)
      2'd0:    return a << amt;
      2'd1:    return a >> amt;
      default: return (a >> amt) | fill;
    endcase
  endfunction

  typedef struct {
    logic [31:0]   z;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt;
  logic        hold_q;
  logic [31:0] hz;
  logic [TW-1:0] ht;
  logic        he;

  // Scoreboard: accepts feed the model queue, output handshakes pop and compare.
  always @(negedge CLK) begin
    if (!RST_N) begin
      exp_q.delete();
      exp_cnt = 16'h0;
      hold_q  = 1'b0;
    end else begin
      chk("op_cnt", 32'(OP_CNT), 32'(exp_cnt));
      if (hold_q) begin
        chk("hold_valid", 32'(OUT_VALID), 32'd1);
        chk("hold_z", OUT_Z, hz);
        chk("hold_tag", 32'(OUT_TAG), 32'(ht));
        chk("hold_err", 32'(OUT_ERR), 32'(he));
      end
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) chk("out_unexpected", 32'(OUT_VALID), 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_z", OUT_Z, e.z);
          chk("sb_tag", 32'(OUT_TAG), 32'(e.tag));
          chk("sb_err", 32'(OUT_ERR), 32'(e.err));
        end
      end
      if (IN_VALID && IN_READY) begin
        exp_t n;
        n.z = ref_z(IN_OP, IN_A, IN_B);
        n.tag = IN_TAG;
        n.err = (IN_OP == 2'd3);
        exp_q.push_back(n);
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
      hold_q = OUT_VALID && !OUT_READY;
      hz = OUT_Z; ht = OUT_TAG; he = OUT_ERR;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [7:0] b, input logic [TW-1:0] t);
    IN_VALID = v; IN_OP = op; IN_A = a; IN_B = b; IN_TAG = t;
  endtask

  // One op into an idle pipeline with OUT_READY high; checks latency and result.
  task automatic send_chk(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [7:0] b, input logic [TW-1:0] t,
                          input logic [31:0] ez, input logic ee);
    OUT_READY = 1'b1;
    drive(1'b1, op, a, b, t);
    tick();
    IN_VALID = 1'b0;
    chk({nm, "_early"}, 32'(OUT_VALID), 32'd0);
    tick();
    chk({nm, "_valid"}, 32'(OUT_VALID), 32'd1);
    chk({nm, "_z"}, OUT_Z, ez);
    chk({nm, "_tag"}, 32'(OUT_TAG), 32'(t));
    chk({nm, "_err"}, 32'(OUT_ERR), 32'(ee));
    chk({nm, "_shx_hold"}, SH_X, a);
    tick();
  endtask

  logic [31:0] bp_a[4];
  int acc;
  logic r;

  initial begin
    bp_a = '{32'h11, 32'h22, 32'h80000033, 32'h44};
    RST_N = 1'b0; OUT_READY = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 8'h0, '0);
    #2;
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_out_z", OUT_Z, 32'h0);
    chk("rst_out_tag", 32'(OUT_TAG), 32'd0);
    chk("rst_out_err", 32'(OUT_ERR), 32'd0);
    chk("rst_sh", {SH_X[26:0], SH_S}, 32'h0);
    chk("rst_sh_ctl", {30'h0, SH_LEFT, SH_LOG}, 32'h0);
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    chk("rst_op_cnt", 32'(OP_CNT), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    tick();

    // Backpressure: only two ops fit while the output is stalled.
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 2'(acc % 3), bp_a[acc], 8'(acc + 1), 4'(acc + 8));
      @(negedge CLK); r = IN_READY;
      tick();
      if (r) acc++;
    end
    chk("bp_accepts", 32'(acc), 32'd2);
    chk("bp_in_ready", 32'(IN_READY), 32'd0);
    OUT_READY = 1'b1;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      drive(1'b1, 2'(acc % 3), bp_a[acc], 8'(acc + 1), 4'(acc + 8));
      @(negedge CLK); r = IN_READY;
      tick();
      if (r) acc++;
    end
    IN_VALID = 1'b0;
    repeat (4) tick();
    chk("bp_all_accepted", 32'(acc), 32'd4);
    chk("bp_cnt", 32'(OP_CNT), 32'd4);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    send_chk("sll", 2'b00, 32'h00000001, 8'd4, 4'd3, 32'h00000010, 1'b0);
    send_chk("sra31", 2'b10, 32'h80000000, 8'd31, 4'd5, 32'hFFFFFFFF, 1'b0);
    send_chk("srl31", 2'b01, 32'h80000000, 8'd31, 4'd6, 32'h00000001, 1'b0);
    send_chk("rsvd", 2'b11, 32'hDEADBEEF, 8'd3, 4'd7, 32'h00000000, 1'b1);
    chk("rsvd_cnt", 32'(OP_CNT), 32'd8);
`ifdef SHIFT_OVF_SAT_EN
    send_chk("srl40", 2'b01, 32'hFFFFFFFF, 8'd40, 4'd9, 32'h00000000, 1'b0);
    send_chk("sra200", 2'b10, 32'h80000000, 8'd200, 4'd10, 32'hFFFFFFFF, 1'b0);
`else
    send_chk("srl40", 2'b01, 32'hFFFFFFFF, 8'd40, 4'd9, 32'h00FFFFFF, 1'b0);
    send_chk("sra200", 2'b10, 32'h80000000, 8'd200, 4'd10, 32'hFF800000, 1'b0);
`endif

    // Random traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(99) < 70, 2'($urandom_range(3)), $urandom,
            8'($urandom_range(255)), 4'($urandom_range(15)));
      OUT_READY = $urandom_range(99) < 60;
      tick();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (4) tick();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    // Reset with both stages full
    OUT_READY = 1'b0;
    drive(1'b1, 2'b00, 32'h5, 8'd1, 4'd1);
    tick();
    drive(1'b1, 2'b01, 32'h50, 8'd2, 4'd2);
    tick();
    IN_VALID = 1'b0;
    chk("full_out_valid", 32'(OUT_VALID), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(OUT_VALID), 32'd0);
    chk("mid_rst_cnt", 32'(OP_CNT), 32'd0);
    chk("mid_rst_ready", 32'(IN_READY), 32'd1);
    tick();
    RST_N = 1'b1; OUT_READY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("no_stale", 32'(OUT_VALID), 32'd0);
    end

    // Counter saturation
    OUT_READY = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      drive(1'b1, 2'($urandom_range(3)), $urandom, 8'($urandom_range(255)), 4'($urandom_range(15)));
      tick();
    end
    IN_VALID = 1'b0;
    repeat (4) tick();
    chk("sat_cnt", 32'(OP_CNT), 32'h0000FFFF);
    chk("sat_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_issue.md
SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 SHALL have parameter: TAG_W, 4, width of the op tag carried alongside each operation.
REQ-002 SHALL have ports (name, direction, width, meaning):
- CLK  input  1  single clock; all state on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  upstream op valid.
- IN_READY  output  1  op accepted when IN_VALID & IN_READY.
- IN_OP  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
- IN_A  input  32  operand to shift.
- IN_B  input  8  shift amount.
- IN_TAG  input  TAG_W  op tag.
- SH_X  output  32  shifter data input.
- SH_S  output  5  shifter amount.
- SH_LEFT  output  1  shifter direction, 1 = left.
- SH_LOG  output  1  shifter mode, 1 = logical.
- SH_Z  input  32  combinational shifter result.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts when OUT_VALID & OUT_READY.
- OUT_Z  output  32  result.
- OUT_TAG  output  TAG_W  tag of result.
- OUT_ERR  output  1  reserved-op flag.
- OP_CNT  output  16  accepted-op counter.

Function
REQ-003 SHALL implement two register stages: S1 (operand/decode, drives SH_*) and S2 (result, drives OUT_*), each with its own valid bit.
REQ-004 SHALL compute s2_free = !S2.valid | OUT_READY, and s1_adv = S1.valid & s2_free.
REQ-005 SHALL drive IN_READY = !S1.valid | s2_free, combinationally.
REQ-006 On accept, S1 SHALL load the following fields: X=IN_A; S=IN_B[4:0]; LEFT=(IN_OP==00); LOG=(IN_OP!=10); tag; err=(IN_OP==11).
REQ-007 When s1_adv, S2 SHALL capture SH_Z (forced to 0 when S1.err), the S1 tag and the S1 err flag.
REQ-008 When s2_free and !S1.valid, S2.valid SHALL clear.
REQ-009 When no new op is accepted, S1.valid SHALL clear on s1_adv.
REQ-010 SHALL give a latency of exactly 2 cycles from the accept edge to OUT_VALID under no backpressure.
REQ-011 SHALL sustain a throughput of 1 op/cycle.
REQ-012 Simultaneous accept and s1_adv SHALL load S1 with the new op while S2 takes the old one.
REQ-013 SH_* SHALL hold their last S1 values when S1 is empty.
REQ-014 OUT_Z, OUT_TAG and OUT_ERR SHALL be stable while OUT_VALID & !OUT_READY.
REQ-015 Ops SHALL leave in acceptance order, with none lost or duplicated under any OUT_READY pattern.
REQ-016 OP_CNT SHALL increment on each accept, including reserved ops.
REQ-017 OP_CNT SHALL saturate at 0xFFFF.

Reset
REQ-018 While RST_N is low, the block SHALL asynchronously clear S1.valid, S2.valid and all S1/S2 data registers, and drive OP_CNT=0.
REQ-019 Reset values seen at the outputs SHALL be OUT_VALID=0, OUT_Z=0, OUT_TAG=0, OUT_ERR=0, SH_X=0, SH_S=0, SH_LEFT=0, SH_LOG=0.
REQ-020 IN_READY SHALL read 1 during reset.
REQ-021 In-flight ops at reset SHALL be discarded.
REQ-022 Reset deassertion SHALL take effect on the next CLK edge.

Configuration
REQ-023 SHALL support macro SHIFT_OVF_SAT_EN.
REQ-024 With SHIFT_OVF_SAT_EN defined, S1 SHALL store ovf=(IN_B[7:5]!=0).
REQ-025 With SHIFT_OVF_SAT_EN defined, when ovf is set S2 SHALL capture 0 for SLL/SRL and {32{S1.X[31]}} for SRA instead of SH_Z.
REQ-026 With SHIFT_OVF_SAT_EN undefined, IN_B[7:5] SHALL be ignored (amount modulo 32) and no ovf register SHALL exist.

Verification
REQ-027 Bench: SLL A=0x00000001 B=4 TAG=3, OUT_READY=1 -> two edges later OUT_VALID=1, OUT_Z=0x00000010, OUT_TAG=3, OUT_ERR=0.
REQ-028 Bench: SRA A=0x80000000 B=31 -> OUT_Z=0xFFFFFFFF; SRL same operands -> OUT_Z=0x00000001.
REQ-029 Bench: offer 4 back-to-back ops with OUT_READY=0 -> exactly 2 accepted, then IN_READY=0; OUT_READY=1 -> all 4 emerge in order, OP_CNT=4.
REQ-030 Bench: IN_OP=11 A=0xDEADBEEF -> OUT_Z=0, OUT_ERR=1; OP_CNT increments.
REQ-031 Bench: B=40 SRL A=0xFFFFFFFF -> with macro OUT_Z=0; without macro OUT_Z=0x00FFFFFF. B=200 SRA A=0x80000000 with macro -> 0xFFFFFFFF.
REQ-032 Bench: RST_N low mid-cycle with both stages full -> OUT_VALID=0 and OP_CNT=0 immediately, no stale result after release; 70000 accepts -> OP_CNT=0xFFFF.
